// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - RV32I decode stage producing ALU control codes behind a 2-entry skid buffer
module alu_ctrl_decoder #(
    parameter int TAG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_ctrl,
    output logic                 alu_src_imm,
    output logic                 is_branch,
    output logic                 branch_on_zero,
    output logic                 illegal,
    output logic [TAG_WIDTH-1:0] out_tag
);

    typedef struct packed {
        logic [3:0] ctrl;
        logic       imm;
        logic       br;
        logic       boz;
        logic       ill;
    } dec_t;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    localparam logic [3:0] C_ADD  = 4'b0000, C_SUB  = 4'b0001, C_AND  = 4'b0010,
                           C_OR   = 4'b0011, C_SLL  = 4'b0100, C_SLT  = 4'b0101,
                           C_XOR  = 4'b0110, C_SRL  = 4'b0111, C_SRA  = 4'b1000,
                           C_SRAI = 4'b1001, C_BGE  = 4'b1100, C_BGEU = 4'b1101,
                           C_SLTU = 4'b1111;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;
    dec_t       dec;

    assign opcode        = instr[6:0];
    assign f3            = instr[14:12];
    assign f7            = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec = '0;
        if (instr[1:0] != 2'b11) begin
            dec.ill = 1'b1;
        end else begin
            case (opcode)
                7'b0110011: begin
                    if (f7 == 7'b0000000) begin
                        case (f3)
                            3'b000:  dec.ctrl = C_ADD;
                            3'b001:  dec.ctrl = C_SLL;
                            3'b010:  dec.ctrl = C_SLT;
                            3'b011:  dec.ctrl = C_SLTU;
                            3'b100:  dec.ctrl = C_XOR;
                            3'b101:  dec.ctrl = C_SRL;
                            3'b110:  dec.ctrl = C_OR;
                            default: dec.ctrl = C_AND;
                        endcase
                    end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                        dec.ctrl = C_SUB;
                    end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                        dec.ctrl = C_SRA;
                    end else begin
                        dec.ill = 1'b1;
                    end
                end
                7'b0010011: begin
                    dec.imm = 1'b1;
                    case (f3)
                        3'b000:  dec.ctrl = C_ADD;
                        3'b010:  dec.ctrl = C_SLT;
                        3'b011:  dec.ctrl = C_SLTU;
                        3'b100:  dec.ctrl = C_XOR;
                        3'b110:  dec.ctrl = C_OR;
                        3'b111:  dec.ctrl = C_AND;
                        3'b001: begin
                            if (f7 == 7'b0000000) dec.ctrl = C_SLL;
                            else                  dec.ill  = 1'b1;
                        end
                        default: begin
                            if (f7 == 7'b0000000)      dec.ctrl = C_SRL;
                            else if (f7 == 7'b0100000) dec.ctrl = C_SRAI;
                            else                       dec.ill  = 1'b1;
                        end
                    endcase
                end
                7'b1100011: begin
                    dec.br = 1'b1;
                    case (f3)
                        3'b000: begin
                            dec.ctrl = C_SUB;
                            dec.boz  = 1'b1;
                        end
                        3'b001:  dec.ctrl = C_SUB;
                        3'b100:  dec.ctrl = C_SLT;
                        3'b101:  dec.ctrl = C_BGE;
                        3'b110:  dec.ctrl = C_SLTU;
                        3'b111:  dec.ctrl = C_BGEU;
                        default: dec.ill  = 1'b1;
                    endcase
                end
                7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111: begin
                    dec.ctrl = C_ADD;
                    dec.imm  = 1'b1;
                end
                7'b1100111: begin
                    dec.ctrl = C_ADD;
                    dec.imm  = 1'b1;
                    if (f3 != 3'b000) dec.ill = 1'b1;
                end
                default: dec.ill = 1'b1;
            endcase
        end
        // An illegal bundle carries no control information beyond the flag itself.
        if (dec.ill) begin
            dec.ctrl = 4'b0000;
            dec.imm  = 1'b0;
            dec.br   = 1'b0;
            dec.boz  = 1'b0;
        end
    end

    state_t               state;
    dec_t                 out_dec;
    dec_t                 skid_dec;
    logic [TAG_WIDTH-1:0] skid_tag;
    logic                 in_xfer;
    logic                 out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_dec   <= '0;
            out_tag   <= '0;
            skid_dec  <= '0;
            skid_tag  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        out_dec   <= dec;
                        out_tag   <= in_tag;
                        out_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        out_dec <= dec;
                        out_tag <= in_tag;
                    end else if (in_xfer) begin
                        skid_dec <= dec;
                        skid_tag <= in_tag;
                        in_ready <= 1'b0;
                        state    <= SKID;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        out_dec  <= skid_dec;
                        out_tag  <= skid_tag;
                        in_ready <= 1'b1;
                        state    <= FULL;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign alu_ctrl       = out_dec.ctrl;
    assign alu_src_imm    = out_dec.imm;
    assign is_branch      = out_dec.br;
    assign branch_on_zero = out_dec.boz;
    assign illegal        = out_dec.ill;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb/tb_alu_ctrl_decoder.sv - directed-vector bench for alu_ctrl_decoder
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, in_tag, out_tag;
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm, is_branch, branch_on_zero, illegal;

    int tests_run = 0;
    int tests_failed = 0;
    logic [39:0] exp_q[$];

    alu_ctrl_decoder #(.TAG_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .is_branch(is_branch),
        .branch_on_zero(branch_on_zero), .illegal(illegal), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] bundle(input logic [3:0] c, input logic imm, input logic br,
                                           input logic boz, input logic ill, input logic [31:0] t);
        return {c, imm, br, boz, ill, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, then transfers one instruction and records its expected bundle.
    task automatic drive(input logic [31:0] i, input logic [31:0] t, input logic [39:0] e);
        int n = 0;
        in_valid = 1'b1;
        instr    = i;
        in_tag   = t;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        step();
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("unexpected_bundle", {24'd0, alu_ctrl, alu_src_imm, is_branch, branch_on_zero, illegal, out_tag}, 64'd0);
            else
                check("bundle", {24'd0, alu_ctrl, alu_src_imm, is_branch, branch_on_zero, illegal, out_tag},
                      {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; in_tag = 32'd0;
        step(); step();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data", {alu_ctrl, alu_src_imm, is_branch, branch_on_zero, illegal, out_tag}, 0);

        // 1: single SUB, one-cycle latency
        out_ready = 1'b1;
        drive(32'h40B50533, 32'h100, bundle(4'b0001, 0, 0, 0, 0, 32'h100));
        in_valid = 1'b0;
        check("t1_out_valid", out_valid, 1);
        check("t1_alu_ctrl", alu_ctrl, 4'b0001);
        check("t1_src_imm", alu_src_imm, 0);
        step();
        check("t1_empty", out_valid, 0);

        // 2: back-to-back ADDI / SRAI / BGEU with full throughput
        drive(32'h00100093, 32'h200, bundle(4'b0000, 1, 0, 0, 0, 32'h200));
        check("t2_in_ready0", in_ready, 1);
        drive(32'h4030D093, 32'h204, bundle(4'b1001, 1, 0, 0, 0, 32'h204));
        check("t2_in_ready1", in_ready, 1);
        check("t2_srai_ctrl", alu_ctrl, 4'b1001);
        drive(32'h00B57463, 32'h208, bundle(4'b1101, 0, 1, 0, 0, 32'h208));
        in_valid = 1'b0;
        check("t2_bgeu_branch", is_branch, 1);
        step();

        // 3: BEQ then BNE
        drive(32'h00B50463, 32'h300, bundle(4'b0001, 0, 1, 1, 0, 32'h300));
        check("t3_beq_boz", branch_on_zero, 1);
        drive(32'h00B51463, 32'h304, bundle(4'b0001, 0, 1, 0, 0, 32'h304));
        in_valid = 1'b0;
        check("t3_bne_boz", branch_on_zero, 0);
        step();

        // 4: stall fills skid buffer, release keeps order
        out_ready = 1'b0;
        drive(32'h00B54533, 32'h400, bundle(4'b0110, 0, 0, 0, 0, 32'h400));
        drive(32'h123450B7, 32'h404, bundle(4'b0000, 1, 0, 0, 0, 32'h404));
        check("t4_in_ready_low", in_ready, 0);
        instr = 32'h0015B093; in_tag = 32'h408;
        step();
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_tag", out_tag, 32'h400);
        check("t4_still_low", in_ready, 0);
        out_ready = 1'b1;
        drive(32'h0015B093, 32'h408, bundle(4'b1111, 1, 0, 0, 0, 32'h408));
        in_valid = 1'b0;
        step(); step();

        // 5: illegal encodings are still delivered
        drive(32'h0000007F, 32'h500, bundle(4'b0000, 0, 0, 0, 1, 32'h500));
        check("t5_illegal_op", illegal, 1);
        drive(32'h02000033, 32'h504, bundle(4'b0000, 0, 0, 0, 1, 32'h504));
        check("t5_mul_ctrl", alu_ctrl, 4'b0000);
        drive(32'h000090E7, 32'h508, bundle(4'b0000, 0, 0, 0, 1, 32'h508));
        drive(32'h00000010, 32'h50C, bundle(4'b0000, 0, 0, 0, 1, 32'h50C));
        drive(32'h00B52463, 32'h510, bundle(4'b0000, 0, 0, 0, 1, 32'h510));
        in_valid = 1'b0;
        step(); step();

        // 6: flush while in SKID with an instruction offered
        out_ready = 1'b0;
        drive(32'h40B50533, 32'h600, bundle(4'b0001, 0, 0, 0, 0, 32'h600));
        drive(32'h00B50463, 32'h604, bundle(4'b0001, 0, 1, 1, 0, 32'h604));
        check("t6_skid", in_ready, 0);
        in_valid = 1'b1; instr = 32'h00100093; in_tag = 32'h608;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("t6_out_valid", out_valid, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_data", {alu_ctrl, alu_src_imm, is_branch, branch_on_zero, illegal, out_tag}, 0);
        out_ready = 1'b1;
        step(); step();
        drive(32'h4030D093, 32'h610, bundle(4'b1001, 1, 0, 0, 0, 32'h610));
        in_valid = 1'b0;
        step(); step(); step();

        check("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
